// File: rtl/rib_arbiter_ooo.sv
// rib_arbiter_ooo: N:1 RIB master arbiter with up to OUTSTANDING
// address phases in flight and in-order response routing.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ribm_*            per-master RIB request side (flattened vectors)
//   o_ribm_gnt          address-phase grant to the winning master
//   o_ribm_rsp          response valid, routed to the owning master
//   o_ribm_rdata        slave read data broadcast to every master
//   o_ribs_* / i_ribs_* single RIB slave port
//   o_outstanding       number of accepted-but-unanswered transactions
//
// Optional feature: define RIB_ARB_LOCK_EN to add i_ribm_lock, which lets
// a master pin arbitration to itself after a locked handshake.
module rib_arbiter_ooo #(
    parameter int MASTERS     = 3,
    parameter int OUTSTANDING = 4,
    parameter int ARB_RR      = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [32*MASTERS-1:0]         i_ribm_addr,
    input  logic [MASTERS-1:0]            i_ribm_wrcs,
    input  logic [4*MASTERS-1:0]          i_ribm_mask,
    input  logic [32*MASTERS-1:0]         i_ribm_wdata,
    output logic [32*MASTERS-1:0]         o_ribm_rdata,
    input  logic [MASTERS-1:0]            i_ribm_req,
    output logic [MASTERS-1:0]            o_ribm_gnt,
    output logic [MASTERS-1:0]            o_ribm_rsp,
    input  logic [MASTERS-1:0]            i_ribm_rdy,
`ifdef RIB_ARB_LOCK_EN
    input  logic [MASTERS-1:0]            i_ribm_lock,
`endif
    output logic [31:0]                   o_ribs_addr,
    output logic                          o_ribs_wrcs,
    output logic [3:0]                    o_ribs_mask,
    output logic [31:0]                   o_ribs_wdata,
    input  logic [31:0]                   i_ribs_rdata,
    output logic                          o_ribs_req,
    input  logic                          i_ribs_gnt,
    input  logic                          i_ribs_rsp,
    output logic                          o_ribs_rdy,
    output logic [$clog2(OUTSTANDING):0]  o_outstanding
);

    localparam int IW    = $clog2(MASTERS);
    localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW    = $clog2(OUTSTANDING) + 1;
    localparam int DEPTH = 1 << PW;

    // Per-master views of the flattened request buses
    logic [31:0] addr_a  [MASTERS];
    logic [31:0] wdata_a [MASTERS];
    logic [3:0]  mask_a  [MASTERS];

    for (genvar g = 0; g < MASTERS; g++) begin : g_split
        assign addr_a[g]  = i_ribm_addr[32*g +: 32];
        assign wdata_a[g] = i_ribm_wdata[32*g +: 32];
        assign mask_a[g]  = i_ribm_mask[4*g +: 4];
    end

    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [IW-1:0]      fifo_q [DEPTH];

    logic [MASTERS-1:0] req_eff;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic [MASTERS-1:0] win;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [IW-1:0]      head;

`ifdef RIB_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic          pinned;

    // While the lock holder keeps requesting, nobody else is visible
    assign pinned  = lock_q & i_ribm_req[lock_id_q];
    assign req_eff = pinned ? (MASTERS'(1) << lock_id_q) : i_ribm_req;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (lock_q && (!i_ribm_req[lock_id_q] || !i_ribm_lock[lock_id_q])) begin
            lock_d = 1'b0;
        end
        if (push && i_ribm_lock[win_idx]) begin
            lock_d    = 1'b1;
            lock_id_d = win_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign req_eff = i_ribm_req;
`endif

    // Winner selection. The loops run so that the preferred candidate is
    // assigned last: highest index for fixed priority, nearest to rr_q+1
    // for round-robin.
    always_comb begin
        int idx;
        idx     = 0;
        win_idx = '0;
        win_vld = 1'b0;
        if (ARB_RR != 0) begin
            for (int off = MASTERS; off >= 1; off--) begin
                idx = int'(rr_q) + off;
                if (idx >= MASTERS) begin
                    idx = idx - MASTERS;
                end
                if (req_eff[IW'(idx)]) begin
                    win_idx = IW'(idx);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < MASTERS; i++) begin
                if (req_eff[i]) begin
                    win_idx = IW'(i);
                    win_vld = 1'b1;
                end
            end
        end
    end

    assign win   = win_vld ? (MASTERS'(1) << win_idx) : '0;
    assign full  = (cnt_q == CW'(OUTSTANDING));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_q];

    // Slave-side request mux; win_idx is 0 when nobody requests
    assign o_ribs_addr  = addr_a[win_idx];
    assign o_ribs_wdata = wdata_a[win_idx];
    assign o_ribs_mask  = mask_a[win_idx];
    assign o_ribs_wrcs  = i_ribm_wrcs[win_idx];
    assign o_ribs_req   = (|req_eff) & ~full;
    assign o_ribm_gnt   = win & {MASTERS{i_ribs_gnt & ~full}};
    assign o_ribm_rdata = {MASTERS{i_ribs_rdata}};

    assign push = o_ribs_req & i_ribs_gnt;

    // Response side: only the master at the FIFO head sees the response
    assign o_ribs_rdy = ~empty & i_ribm_rdy[head];
    assign pop        = i_ribs_rsp & o_ribs_rdy;

    always_comb begin
        o_ribm_rsp = '0;
        if (i_ribs_rsp && !empty) begin
            o_ribm_rsp[head] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        rr_d  = rr_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (push) begin
            wr_d = wr_q + 1'b1;
            rr_d = win_idx;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            rr_q  <= IW'(MASTERS - 1);
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            rr_q  <= rr_d;
        end
    end

    // ID storage needs no reset: entries are only read while count > 0
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_q] <= win_idx;
        end
    end

    assign o_outstanding = cnt_q;

endmodule

// File: tb/tb_rib_arbiter_ooo.sv
// tb_rib_arbiter_ooo: directed and randomized checks of rib_arbiter_ooo
// in fixed-priority and round-robin builds sharing the same stimulus.
module tb_rib_arbiter_ooo;

    localparam int M = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [32*M-1:0] addr;
    logic [M-1:0]    wrcs;
    logic [4*M-1:0]  mask;
    logic [32*M-1:0] wdata;
    logic [M-1:0]    req;
    logic [M-1:0]    rdy;
    logic [M-1:0]    lock;
    logic [31:0]     s_rdata;
    logic            s_gnt;
    logic            s_rsp;

    logic [32*M-1:0] fx_rdata, rr_rdata;
    logic [M-1:0]    fx_gnt, rr_gnt;
    logic [M-1:0]    fx_rsp, rr_rsp;
    logic [31:0]     fx_saddr, rr_saddr;
    logic            fx_swrcs, rr_swrcs;
    logic [3:0]      fx_smask, rr_smask;
    logic [31:0]     fx_swdata, rr_swdata;
    logic            fx_sreq, rr_sreq;
    logic            fx_srdy, rr_srdy;
    logic [2:0]      fx_out, rr_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rib_arbiter_ooo #(.MASTERS(M), .OUTSTANDING(4), .ARB_RR(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ribm_addr(addr), .i_ribm_wrcs(wrcs), .i_ribm_mask(mask),
        .i_ribm_wdata(wdata), .o_ribm_rdata(fx_rdata),
        .i_ribm_req(req), .o_ribm_gnt(fx_gnt), .o_ribm_rsp(fx_rsp),
        .i_ribm_rdy(rdy),
`ifdef RIB_ARB_LOCK_EN
        .i_ribm_lock(lock),
`endif
        .o_ribs_addr(fx_saddr), .o_ribs_wrcs(fx_swrcs),
        .o_ribs_mask(fx_smask), .o_ribs_wdata(fx_swdata),
        .i_ribs_rdata(s_rdata), .o_ribs_req(fx_sreq), .i_ribs_gnt(s_gnt),
        .i_ribs_rsp(s_rsp), .o_ribs_rdy(fx_srdy), .o_outstanding(fx_out)
    );

    rib_arbiter_ooo #(.MASTERS(M), .OUTSTANDING(4), .ARB_RR(1)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_ribm_addr(addr), .i_ribm_wrcs(wrcs), .i_ribm_mask(mask),
        .i_ribm_wdata(wdata), .o_ribm_rdata(rr_rdata),
        .i_ribm_req(req), .o_ribm_gnt(rr_gnt), .o_ribm_rsp(rr_rsp),
        .i_ribm_rdy(rdy),
`ifdef RIB_ARB_LOCK_EN
        .i_ribm_lock(lock),
`endif
        .o_ribs_addr(rr_saddr), .o_ribs_wrcs(rr_swrcs),
        .o_ribs_mask(rr_smask), .o_ribs_wdata(rr_swdata),
        .i_ribs_rdata(s_rdata), .o_ribs_req(rr_sreq), .i_ribs_gnt(s_gnt),
        .i_ribs_rsp(s_rsp), .o_ribs_rdy(rr_srdy), .o_outstanding(rr_out)
    );

    task automatic randomize_data();
        addr    = {$urandom, $urandom, $urandom};
        wdata   = {$urandom, $urandom, $urandom};
        mask    = 12'($urandom);
        wrcs    = 3'($urandom);
        s_rdata = $urandom;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        rdy   = '0;
        lock  = '0;
        s_gnt = 1'b0;
        s_rsp = 1'b0;
        randomize_data();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        s_rsp = 1'b1;
        rdy   = '1;
        #1;
        n_checks++;
        if (fx_out !== 3'd0) $display("FAIL reset_count got %0d exp 0", fx_out);
        else n_pass++;
        n_checks++;
        if (rr_out !== 3'd0) $display("FAIL reset_count_rr got %0d exp 0", rr_out);
        else n_pass++;
        n_checks++;
        if (fx_sreq !== 1'b0) $display("FAIL reset_sreq got %b exp 0", fx_sreq);
        else n_pass++;
        n_checks++;
        if (fx_rsp !== 3'b000) $display("FAIL reset_rsp got %b exp 000", fx_rsp);
        else n_pass++;
        n_checks++;
        if (fx_srdy !== 1'b0) $display("FAIL reset_srdy got %b exp 0", fx_srdy);
        else n_pass++;
        n_checks++;
        if (fx_saddr !== addr[31:0])
            $display("FAIL idle_addr got %h exp %h", fx_saddr, addr[31:0]);
        else n_pass++;
        n_checks++;
        if (fx_rdata !== {M{s_rdata}})
            $display("FAIL rdata_bcast got %h exp %h", fx_rdata, {M{s_rdata}});
        else n_pass++;
        @(negedge clk);
        s_rsp = 1'b0;
    endtask

    task automatic test_fixed_priority();
        logic [M-1:0] pats [4];
        int           wins [4];
        logic [M-1:0] one;
        logic [31:0]  ea;
        logic [31:0]  ew;
        logic [3:0]   em;
        pats = '{3'b111, 3'b011, 3'b101, 3'b001};
        wins = '{2, 1, 2, 0};
        one  = 1;
        do_reset();
        s_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = pats[i];
            #1;
            ea = 32'(addr >> (32 * wins[i]));
            ew = 32'(wdata >> (32 * wins[i]));
            em = 4'(mask >> (4 * wins[i]));
            n_checks++;
            if (fx_gnt !== (one << wins[i]))
                $display("FAIL fixed_gnt req=%b got %b exp %b",
                         pats[i], fx_gnt, one << wins[i]);
            else n_pass++;
            n_checks++;
            if (fx_saddr !== ea || fx_swdata !== ew || fx_smask !== em ||
                fx_swrcs !== wrcs[wins[i]])
                $display("FAIL fixed_mux req=%b got %h/%h/%h exp %h/%h/%h",
                         pats[i], fx_saddr, fx_swdata, fx_smask, ea, ew, em);
            else n_pass++;
            n_checks++;
            if (fx_out !== 3'(i))
                $display("FAIL fixed_count got %0d exp %0d", fx_out, i);
            else n_pass++;
            @(negedge clk);
        end
        req   = '0;
        s_gnt = 1'b0;
    endtask

    task automatic test_round_robin();
        int           order [4];
        logic [M-1:0] one;
        order = '{0, 1, 2, 0};
        one   = 1;
        do_reset();
        req   = 3'b111;
        s_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (rr_gnt !== (one << order[c]))
                $display("FAIL rr_order cyc=%0d got %b exp %b",
                         c, rr_gnt, one << order[c]);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (rr_gnt !== 3'b000 || rr_sreq !== 1'b0)
            $display("FAIL rr_full got gnt=%b req=%b exp 000/0", rr_gnt, rr_sreq);
        else n_pass++;
        req   = '0;
        s_gnt = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        req   = 3'b010;
        s_gnt = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (fx_out !== 3'd4) $display("FAIL full_count got %0d exp 4", fx_out);
        else n_pass++;
        n_checks++;
        if (fx_sreq !== 1'b0 || fx_gnt !== 3'b000)
            $display("FAIL full_block got req=%b gnt=%b exp 0/000", fx_sreq, fx_gnt);
        else n_pass++;
        s_rsp = 1'b1;
        rdy   = '1;
        #1;
        n_checks++;
        if (fx_sreq !== 1'b0 || fx_gnt !== 3'b000 || fx_rsp !== 3'b010)
            $display("FAIL full_pop_no_push got req=%b gnt=%b rsp=%b exp 0/000/010",
                     fx_sreq, fx_gnt, fx_rsp);
        else n_pass++;
        @(negedge clk);
        s_rsp = 1'b0;
        #1;
        n_checks++;
        if (fx_out !== 3'd3 || fx_sreq !== 1'b1 || fx_gnt !== 3'b010)
            $display("FAIL after_pop got cnt=%0d req=%b gnt=%b exp 3/1/010",
                     fx_out, fx_sreq, fx_gnt);
        else n_pass++;
        req   = '0;
        s_gnt = 1'b0;
    endtask

    task automatic test_in_order();
        int           ms [3];
        logic [M-1:0] one;
        ms  = '{2, 0, 1};
        one = 1;
        do_reset();
        s_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = one << ms[i];
            @(negedge clk);
        end
        req   = '0;
        s_gnt = 1'b0;
        s_rsp = 1'b1;
        rdy   = '1;
        for (int r = 0; r < 3; r++) begin
            #1;
            n_checks++;
            if (fx_rsp !== (one << ms[r]))
                $display("FAIL inorder_rsp idx=%0d got %b exp %b",
                         r, fx_rsp, one << ms[r]);
            else n_pass++;
            @(negedge clk);
        end
        s_rsp = 1'b0;
        #1;
        n_checks++;
        if (fx_out !== 3'd0) $display("FAIL inorder_drain got %0d exp 0", fx_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        req   = 3'b010;
        s_gnt = 1'b1;
        @(negedge clk);
        req   = '0;
        s_gnt = 1'b0;
        s_rsp = 1'b1;
        rdy   = 3'b101;
        #1;
        n_checks++;
        if (fx_srdy !== 1'b0 || fx_rsp !== 3'b010)
            $display("FAIL bp_hold got rdy=%b rsp=%b exp 0/010", fx_srdy, fx_rsp);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (fx_out !== 3'd1) $display("FAIL bp_nopop got %0d exp 1", fx_out);
        else n_pass++;
        rdy = 3'b111;
        #1;
        n_checks++;
        if (fx_srdy !== 1'b1) $display("FAIL bp_release got %b exp 1", fx_srdy);
        else n_pass++;
        @(negedge clk);
        s_rsp = 1'b0;
        #1;
        n_checks++;
        if (fx_out !== 3'd0) $display("FAIL bp_pop got %0d exp 0", fx_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req   = 3'b001;
        s_gnt = 1'b1;
        repeat (3) @(negedge clk);
        req   = '0;
        s_gnt = 1'b0;
        #1;
        n_checks++;
        if (fx_out !== 3'd3) $display("FAIL mid_fill got %0d exp 3", fx_out);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        s_rsp = 1'b1;
        rdy   = '1;
        #1;
        n_checks++;
        if (fx_rsp !== 3'b000 || fx_out !== 3'd0 || fx_srdy !== 1'b0)
            $display("FAIL mid_reset got rsp=%b cnt=%0d rdy=%b exp 000/0/0",
                     fx_rsp, fx_out, fx_srdy);
        else n_pass++;
        @(negedge clk);
        s_rsp = 1'b0;
    endtask

    // Reference model: a queue of owner IDs, and the last-granted master
    // for the round-robin search.
    task automatic test_random(input bit use_rr);
        int           q [$];
        int           last;
        int           w;
        bit           any;
        bit           full;
        logic [M-1:0] one;
        logic         e_sreq, e_srdy;
        logic [M-1:0] e_gnt, e_rsp;
        logic [31:0]  e_addr;
        logic         o_sreq, o_srdy;
        logic [M-1:0] o_gnt, o_rsp;
        logic [31:0]  o_addr;
        logic [2:0]   o_cnt;
        one  = 1;
        last = M - 1;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            randomize_data();
            req   = 3'($urandom);
            rdy   = 3'($urandom);
            s_gnt = ($urandom % 4) != 0;
            s_rsp = ($urandom % 3) == 0;
            any   = req != '0;
            full  = q.size() == 4;
            w     = 0;
            if (use_rr) begin
                for (int off = M; off >= 1; off--) begin
                    if (req[(last + off) % M]) w = (last + off) % M;
                end
            end else begin
                for (int i = 0; i < M; i++) if (req[i]) w = i;
            end
            e_sreq = any && !full;
            e_gnt  = (e_sreq && s_gnt) ? (one << w) : '0;
            e_addr = 32'(addr >> (32 * w));
            e_rsp  = (s_rsp && q.size() > 0) ? (one << q[0]) : '0;
            e_srdy = (q.size() > 0) && (((rdy >> q[0]) & 3'b001) != '0);
            #1;
            o_sreq = use_rr ? rr_sreq  : fx_sreq;
            o_srdy = use_rr ? rr_srdy  : fx_srdy;
            o_gnt  = use_rr ? rr_gnt   : fx_gnt;
            o_rsp  = use_rr ? rr_rsp   : fx_rsp;
            o_addr = use_rr ? rr_saddr : fx_saddr;
            o_cnt  = use_rr ? rr_out   : fx_out;
            n_checks++;
            if (o_sreq !== e_sreq)
                $display("FAIL rnd_sreq rr=%0d cyc=%0d got %b exp %b", use_rr, cyc, o_sreq, e_sreq);
            else n_pass++;
            n_checks++;
            if (o_gnt !== e_gnt)
                $display("FAIL rnd_gnt rr=%0d cyc=%0d got %b exp %b", use_rr, cyc, o_gnt, e_gnt);
            else n_pass++;
            n_checks++;
            if (o_addr !== e_addr)
                $display("FAIL rnd_addr rr=%0d cyc=%0d got %h exp %h", use_rr, cyc, o_addr, e_addr);
            else n_pass++;
            n_checks++;
            if (o_rsp !== e_rsp)
                $display("FAIL rnd_rsp rr=%0d cyc=%0d got %b exp %b", use_rr, cyc, o_rsp, e_rsp);
            else n_pass++;
            n_checks++;
            if (o_srdy !== e_srdy)
                $display("FAIL rnd_srdy rr=%0d cyc=%0d got %b exp %b", use_rr, cyc, o_srdy, e_srdy);
            else n_pass++;
            n_checks++;
            if (o_cnt !== 3'(q.size()))
                $display("FAIL rnd_count rr=%0d cyc=%0d got %0d exp %0d", use_rr, cyc, o_cnt, q.size());
            else n_pass++;
            if (e_srdy && s_rsp) void'(q.pop_front());
            if (e_sreq && s_gnt) begin
                q.push_back(w);
                last = w;
            end
            @(negedge clk);
        end
        req   = '0;
        s_gnt = 1'b0;
        s_rsp = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_full();
        test_in_order();
        test_backpressure();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
